// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Imported by the control FSM and its testbench-facing interface users.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    FETCH,
    DECODE,
    R_EXE,
    I_EXE,
    B_EXE,
    LU_EXE,
    AU_EXE,
    J_EXE,
    JL_EXE,
    S_EXE,
    S_MEM,
    L_EXE,
    L_MEM,
    L_WB,
    MD_EXE,
    MD_WAIT,
    MD_WB,
    TRAP
  } state_e;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_TIMEOUT = 2'b10,
    TC_MEXT    = 2'b11
  } trap_cause_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_L     = 7'b0000011;

  localparam logic [2:0] RFWD_ALU   = 3'b000;
  localparam logic [2:0] RFWD_LOAD  = 3'b001;
  localparam logic [2:0] RFWD_LUI   = 3'b010;
  localparam logic [2:0] RFWD_AUIPC = 3'b011;
  localparam logic [2:0] RFWD_PC4   = 3'b100;
  localparam logic [2:0] RFWD_MD    = 3'b101;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [6:0] MEXT_FUNCT7 = 7'b0000001;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_MEM) || (s == L_MEM);
  endfunction

endpackage

// File: rtl/mc_ctrl_unit_if.sv
// Data-bus and mul/div handshake bundle between the control unit and its peers.
// The control unit is the master: it issues requests and receives completions.
interface mc_ctrl_unit_if;
  logic       busReq;
  logic       busWe;
  logic [2:0] strb;
  logic       busReady;
  logic       mdStart;
  logic [2:0] mdOp;
  logic       mdDone;

  modport master (
    output busReq, busWe, strb, mdStart, mdOp,
    input  busReady, mdDone
  );

  modport slave (
    input  busReq, busWe, strb, mdStart, mdOp,
    output busReady, mdDone
  );
endinterface

// File: rtl/mc_bus_timer.sv
// Clearable saturating cycle counter that flags when a memory access has
// waited BUS_TIMEOUT cycles (expired is high during the last allowed cycle).
module mc_bus_timer #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BUS_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Saturates at LAST so a long stall can never wrap back to a fresh window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle RV32I control FSM with wait-state bus handshake, optional RV32M
// sequencing, bus-timeout detection and sticky illegal-instruction trapping.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter bit EN_MEXT     = 1'b0,
  parameter int BUS_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instrCode,
  mc_ctrl_unit_if.master       bus,
  output logic                 PCEn,
  output logic                 regFileWe,
  output logic                 aluSrcMuxSel,
  output logic [3:0]           aluControl,
  output logic [2:0]           RFWDSrcMuxSel,
  output logic                 branch,
  output logic                 jal,
  output logic                 jalr,
  output logic                 trap,
  output logic [1:0]           trapCause
);

  state_e      state;
  state_e      state_next;
  trap_cause_e cause_q;
  trap_cause_e cause_next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alu_full;
  logic       in_mem;
  logic       bus_expired;
  logic       unused_fields;

  assign opcode   = instrCode[6:0];
  assign funct3   = instrCode[14:12];
  assign funct7   = instrCode[31:25];
  assign alu_full = {instrCode[30], funct3};
  assign in_mem   = is_mem_state(state);

  // Register indices and immediates belong to the datapath, not to control.
  assign unused_fields = ^{instrCode[24:15], instrCode[11:7]};

  mc_bus_timer #(
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_bus_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (!in_mem),
    .en     (in_mem),
    .expired(bus_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      cause_q <= TC_NONE;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
    end
  end

  always_comb begin
    state_next    = state;
    cause_next    = cause_q;
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    aluControl    = alu_full;
    RFWDSrcMuxSel = RFWD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    bus.busReq    = 1'b0;
    bus.busWe     = 1'b0;
    bus.mdStart   = 1'b0;

    case (state)
      FETCH: begin
        PCEn       = 1'b1;
        state_next = DECODE;
      end

      DECODE: begin
        case (opcode)
          OP_R: begin
            if (funct7 == MEXT_FUNCT7) begin
              if (EN_MEXT) begin
                state_next = MD_EXE;
              end else begin
                state_next = TRAP;
                cause_next = TC_MEXT;
              end
            end else begin
              state_next = R_EXE;
            end
          end
          OP_I:     state_next = I_EXE;
          OP_B:     state_next = B_EXE;
          OP_LUI:   state_next = LU_EXE;
          OP_AUIPC: state_next = AU_EXE;
          OP_JAL:   state_next = J_EXE;
          OP_JALR:  state_next = JL_EXE;
          OP_S:     state_next = S_EXE;
          OP_L:     state_next = L_EXE;
          default: begin
            state_next = TRAP;
            cause_next = TC_ILLEGAL;
          end
        endcase
      end

      R_EXE: begin
        regFileWe  = 1'b1;
        state_next = FETCH;
      end

      I_EXE: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        // Bit 30 is immediate data except for the shift-right pair.
        aluControl   = (funct3 == 3'b101) ? alu_full : {1'b0, funct3};
        state_next   = FETCH;
      end

      B_EXE: begin
        branch     = 1'b1;
        state_next = FETCH;
      end

      LU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_LUI;
        state_next    = FETCH;
      end

      AU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_AUIPC;
        state_next    = FETCH;
      end

      J_EXE: begin
        regFileWe     = 1'b1;
        jal           = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
        state_next    = FETCH;
      end

      JL_EXE: begin
        regFileWe     = 1'b1;
        jal           = 1'b1;
        jalr          = 1'b1;
        aluControl    = ALU_ADD;
        RFWDSrcMuxSel = RFWD_PC4;
        state_next    = FETCH;
      end

      S_EXE: begin
        aluSrcMuxSel = 1'b1;
        aluControl   = ALU_ADD;
        state_next   = S_MEM;
      end

      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        aluControl   = ALU_ADD;
        bus.busReq   = 1'b1;
        bus.busWe    = 1'b1;
        // Completion wins over timeout in the final allowed cycle.
        if (bus.busReady) begin
          state_next = FETCH;
        end else if (bus_expired) begin
          state_next = TRAP;
          cause_next = TC_TIMEOUT;
        end
      end

      L_EXE: begin
        aluSrcMuxSel = 1'b1;
        aluControl   = ALU_ADD;
        state_next   = L_MEM;
      end

      L_MEM: begin
        aluSrcMuxSel = 1'b1;
        aluControl   = ALU_ADD;
        bus.busReq   = 1'b1;
        if (bus.busReady) begin
          state_next = L_WB;
        end else if (bus_expired) begin
          state_next = TRAP;
          cause_next = TC_TIMEOUT;
        end
      end

      L_WB: begin
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        aluControl    = ALU_ADD;
        RFWDSrcMuxSel = RFWD_LOAD;
        state_next    = FETCH;
      end

      MD_EXE: begin
        bus.mdStart = 1'b1;
        state_next  = MD_WAIT;
      end

      MD_WAIT: begin
        if (bus.mdDone) begin
          state_next = MD_WB;
        end
      end

      MD_WB: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_MD;
        state_next    = FETCH;
      end

      TRAP: begin
        state_next = TRAP;
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign trap      = (state == TRAP);
  assign trapCause = cause_q;
  assign bus.strb  = funct3;
  assign bus.mdOp  = funct3;

endmodule
